// File: rtl/mdr_mem_ctrl.sv
// rtl/mdr_mem_ctrl.sv - MDR/MAR memory access sequencer with strobe timeout
module mdr_mem_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic clr,
    input  logic rd_req,
    input  logic wr_req,
    input  logic mem_ack,
    output logic MARin,
    output logic MDRin,
    output logic Read,
    output logic mem_rd,
    output logic mem_wr,
    output logic busy,
    output logic done,
    output logic err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_WDATA   = 3'd2,
        S_RD_WAIT = 3'd3,
        S_WR_WAIT = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic       OP_RD   = 1'b0;
    localparam logic       OP_WR   = 1'b1;
    localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

    state_t     r_state;
    state_t     w_next;
    logic       r_op;
    logic [7:0] r_wait_cnt;
    logic       r_err;

    logic w_in_wait;
    logic w_wait_last;
    logic w_accept;
    logic w_timeout;

    assign w_in_wait   = (r_state == S_RD_WAIT) || (r_state == S_WR_WAIT);
    assign w_wait_last = (r_wait_cnt == LP_LAST);
    assign w_accept    = (r_state == S_IDLE) && (rd_req || wr_req);
    assign w_timeout   = w_in_wait && !mem_ack && w_wait_last;
    assign err         = r_err;

    // State register; reset returns to IDLE without waiting for a clock edge
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and outputs; MDRin in RD_WAIT follows mem_ack so MDR loads on the ack edge
    always_comb begin
        w_next = r_state;
        MARin  = 1'b0;
        MDRin  = 1'b0;
        Read   = 1'b0;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rd_req || wr_req) begin
                    w_next = S_ADDR;
                end
            end
            S_ADDR: begin
                MARin  = 1'b1;
                busy   = 1'b1;
                w_next = (r_op == OP_RD) ? S_RD_WAIT : S_WDATA;
            end
            S_WDATA: begin
                MDRin  = 1'b1;
                busy   = 1'b1;
                w_next = S_WR_WAIT;
            end
            S_RD_WAIT: begin
                mem_rd = 1'b1;
                Read   = 1'b1;
                MDRin  = mem_ack;
                busy   = 1'b1;
                if (mem_ack || w_wait_last) begin
                    w_next = S_DONE;
                end
            end
            S_WR_WAIT: begin
                mem_wr = 1'b1;
                busy   = 1'b1;
                if (mem_ack || w_wait_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operation latch, wait counter (zero outside wait states) and sticky timeout flag
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_op       <= OP_RD;
            r_wait_cnt <= 8'd0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op  <= rd_req ? OP_RD : OP_WR;
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
            if (w_in_wait && !mem_ack && !w_wait_last) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end else begin
                r_wait_cnt <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_mdr_mem_ctrl.sv
// tb/tb_mdr_mem_ctrl.sv - directed self-checking bench for mdr_mem_ctrl
module tb_mdr_mem_ctrl;

    logic clk;
    logic clr;
    logic rd_req;
    logic wr_req;
    logic mem_ack;
    logic MARin;
    logic MDRin;
    logic Read;
    logic mem_rd;
    logic mem_wr;
    logic busy;
    logic done;
    logic err;

    logic [7:0] mdatain;
    logic [7:0] busmux;
    logic [7:0] mdr;
    logic [6:0] o;

    int checks;
    int errors;

    // {MARin, MDRin, Read, mem_rd, mem_wr, busy, done}
    localparam logic [6:0] V_IDLE  = 7'b0000000;
    localparam logic [6:0] V_ADDR  = 7'b1000010;
    localparam logic [6:0] V_WDATA = 7'b0100010;
    localparam logic [6:0] V_RDW   = 7'b0011010;
    localparam logic [6:0] V_RDACK = 7'b0111010;
    localparam logic [6:0] V_WRW   = 7'b0000110;
    localparam logic [6:0] V_DONE  = 7'b0000001;

    mdr_mem_ctrl #(.TIMEOUT(4)) dut (
        .clk     (clk),
        .clr     (clr),
        .rd_req  (rd_req),
        .wr_req  (wr_req),
        .mem_ack (mem_ack),
        .MARin   (MARin),
        .MDRin   (MDRin),
        .Read    (Read),
        .mem_rd  (mem_rd),
        .mem_wr  (mem_wr),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    assign o = {MARin, MDRin, Read, mem_rd, mem_wr, busy, done};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // MDR register outside the controller, steered by MDRin/Read
    always @(posedge clk) begin
        if (MDRin) mdr <= Read ? mdatain : busmux;
    end

    task test_reset;
        clr = 1'b0; rd_req = 1'b0; wr_req = 1'b0; mem_ack = 1'b0;
        mdatain = 8'h00; busmux = 8'h00; mdr = 8'h00;
        @(negedge clk);
        checks++;
        if (o !== V_IDLE || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got o=%b err=%b, want o=%b err=0", o, err, V_IDLE);
        end
        clr = 1'b1;
        @(negedge clk);
        checks++;
        if (o !== V_IDLE) begin
            errors++;
            $display("FAIL reset_idle: got o=%b, want %b", o, V_IDLE);
        end
    endtask

    task test_read;
        mdatain = 8'hA5; busmux = 8'h11;
        rd_req = 1'b1;
        @(negedge clk); rd_req = 1'b0;
        checks++;
        if (o !== V_ADDR) begin
            errors++; $display("FAIL read_addr: got o=%b, want %b", o, V_ADDR);
        end
        @(negedge clk);
        checks++;
        if (o !== V_RDW) begin
            errors++; $display("FAIL read_wait: got o=%b, want %b", o, V_RDW);
        end
        mem_ack = 1'b1; #1;
        checks++;
        if (o !== V_RDACK) begin
            errors++; $display("FAIL read_mealy_mdrin: got o=%b, want %b", o, V_RDACK);
        end
        @(negedge clk); mem_ack = 1'b0;
        checks++;
        if (o !== V_DONE || err !== 1'b0) begin
            errors++; $display("FAIL read_done: got o=%b err=%b, want o=%b err=0", o, err, V_DONE);
        end
        checks++;
        if (mdr !== 8'hA5) begin
            errors++; $display("FAIL read_mdr: got %h, want a5", mdr);
        end
        @(negedge clk);
        checks++;
        if (o !== V_IDLE) begin
            errors++; $display("FAIL read_back_idle: got o=%b, want %b", o, V_IDLE);
        end
    endtask

    task test_write;
        busmux = 8'd30; mdatain = 8'h55;
        wr_req = 1'b1;
        @(negedge clk); wr_req = 1'b0;
        checks++;
        if (o !== V_ADDR) begin
            errors++; $display("FAIL write_addr: got o=%b, want %b", o, V_ADDR);
        end
        @(negedge clk);
        checks++;
        if (o !== V_WDATA) begin
            errors++; $display("FAIL write_wdata: got o=%b, want %b", o, V_WDATA);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (o !== V_WRW) begin
                errors++; $display("FAIL write_wait_%0d: got o=%b, want %b", i, o, V_WRW);
            end
            if (i == 3) mem_ack = 1'b1;
        end
        @(negedge clk); mem_ack = 1'b0;
        checks++;
        if (o !== V_DONE || err !== 1'b0) begin
            errors++; $display("FAIL write_done_last_cycle_ack: got o=%b err=%b, want o=%b err=0", o, err, V_DONE);
        end
        checks++;
        if (mdr !== 8'd30) begin
            errors++; $display("FAIL write_mdr: got %0d, want 30", mdr);
        end
        @(negedge clk);
    endtask

    task test_timeout;
        int n;
        logic saw_mdrin;
        n = 0; saw_mdrin = 1'b0;
        mdatain = 8'h77;
        rd_req = 1'b1;
        @(negedge clk); rd_req = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 20 && mem_rd; i++) begin
            n++;
            if (MDRin) saw_mdrin = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (n !== 4) begin
            errors++; $display("FAIL timeout_strobe_len: got %0d cycles, want 4", n);
        end
        checks++;
        if (saw_mdrin !== 1'b0 || mdr !== 8'd30) begin
            errors++; $display("FAIL timeout_no_load: got mdrin_seen=%b mdr=%0d, want 0 and 30", saw_mdrin, mdr);
        end
        checks++;
        if (o !== V_DONE || err !== 1'b1) begin
            errors++; $display("FAIL timeout_done: got o=%b err=%b, want o=%b err=1", o, err, V_DONE);
        end
        @(negedge clk);
        checks++;
        if (o !== V_IDLE || err !== 1'b1) begin
            errors++; $display("FAIL timeout_err_sticky: got o=%b err=%b, want o=%b err=1", o, err, V_IDLE);
        end
        wr_req = 1'b1;
        @(negedge clk); wr_req = 1'b0;
        checks++;
        if (o !== V_ADDR || err !== 1'b0) begin
            errors++; $display("FAIL timeout_err_clear: got o=%b err=%b, want o=%b err=0", o, err, V_ADDR);
        end
        @(negedge clk);
        @(negedge clk); mem_ack = 1'b1;
        @(negedge clk); mem_ack = 1'b0;
        checks++;
        if (o !== V_DONE || err !== 1'b0) begin
            errors++; $display("FAIL timeout_followup_write: got o=%b err=%b, want o=%b err=0", o, err, V_DONE);
        end
        @(negedge clk);
    endtask

    task test_both_req;
        logic saw_rd, saw_wr, saw_done;
        int busy_cycles;
        saw_rd = 1'b0; saw_wr = 1'b0; saw_done = 1'b0; busy_cycles = 0;
        rd_req = 1'b1; wr_req = 1'b1;
        @(negedge clk); rd_req = 1'b0; wr_req = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (mem_wr) saw_wr = 1'b1;
            if (busy) busy_cycles++;
            if (done) saw_done = 1'b1;
            if (mem_rd) begin saw_rd = 1'b1; mem_ack = 1'b1; end
            else mem_ack = 1'b0;
            @(negedge clk);
        end
        mem_ack = 1'b0;
        checks++;
        if (saw_rd !== 1'b1 || saw_wr !== 1'b0 || saw_done !== 1'b1) begin
            errors++; $display("FAIL both_req_read_wins: got rd=%b wr=%b done=%b, want 1 0 1", saw_rd, saw_wr, saw_done);
        end
        checks++;
        if (busy_cycles !== 2) begin
            errors++; $display("FAIL both_req_no_write_follows: got busy cycles %0d, want 2", busy_cycles);
        end
    endtask

    task test_reset_mid;
        logic saw_done;
        saw_done = 1'b0;
        rd_req = 1'b1;
        @(negedge clk); rd_req = 1'b0;
        @(negedge clk);
        checks++;
        if (o !== V_RDW) begin
            errors++; $display("FAIL rstmid_in_wait: got o=%b, want %b", o, V_RDW);
        end
        #2 clr = 1'b0;
        #1;
        checks++;
        if (o !== V_IDLE || err !== 1'b0) begin
            errors++; $display("FAIL rstmid_async_drop: got o=%b err=%b, want all 0", o, err);
        end
        @(negedge clk);
        if (done) saw_done = 1'b1;
        clr = 1'b1; rd_req = 1'b1;
        @(negedge clk); rd_req = 1'b0;
        if (done) saw_done = 1'b1;
        checks++;
        if (o !== V_ADDR || saw_done !== 1'b0) begin
            errors++; $display("FAIL rstmid_first_edge_accept: got o=%b done_seen=%b, want o=%b done_seen=0", o, saw_done, V_ADDR);
        end
        @(negedge clk); mem_ack = 1'b1;
        @(negedge clk); mem_ack = 1'b0;
        checks++;
        if (o !== V_DONE || err !== 1'b0) begin
            errors++; $display("FAIL rstmid_recover_read: got o=%b err=%b, want o=%b err=0", o, err, V_DONE);
        end
        @(negedge clk);
    endtask

    task test_stray_ack;
        mem_ack = 1'b1; #1;
        checks++;
        if (o !== V_IDLE) begin
            errors++; $display("FAIL stray_idle_comb: got o=%b, want %b", o, V_IDLE);
        end
        @(negedge clk);
        checks++;
        if (o !== V_IDLE) begin
            errors++; $display("FAIL stray_idle_state: got o=%b, want %b", o, V_IDLE);
        end
        rd_req = 1'b1;
        @(negedge clk); rd_req = 1'b0;
        checks++;
        if (o !== V_ADDR) begin
            errors++; $display("FAIL stray_addr: got o=%b, want %b", o, V_ADDR);
        end
        mem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (o !== V_RDW) begin
            errors++; $display("FAIL stray_addr_to_wait: got o=%b, want %b", o, V_RDW);
        end
        mem_ack = 1'b1;
        @(negedge clk);
        rd_req = 1'b1; wr_req = 1'b1; #1;
        checks++;
        if (o !== V_DONE) begin
            errors++; $display("FAIL stray_done_comb: got o=%b, want %b", o, V_DONE);
        end
        @(negedge clk); rd_req = 1'b0; wr_req = 1'b0; mem_ack = 1'b0;
        checks++;
        if (o !== V_IDLE) begin
            errors++; $display("FAIL stray_done_req_ignored: got o=%b, want %b", o, V_IDLE);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset;
        test_read;
        test_write;
        test_timeout;
        test_both_req;
        test_reset_mid;
        test_stray_ack;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
